ser_word_serializer: RTL and testbench
======================================

Name: ser_word_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clk, on serial_out.
- serial_out drives the detector's serial_in directly; IDLE_BIT fills idle and gap cycles.
- A one-word holding register allows back-to-back words with no bubble when GAP=0.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- GAP, 0: idle cycles inserted between consecutive words; legal range 0..15.
- IDLE_BIT, 1'b1: level driven on serial_out when no data bit is being sent.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding register empty; equals ~hold_full, derived from a register only.
- serial_out  output  1  registered serial bit; feeds detector serial_in.
- serial_valid  output  1  registered; high while serial_out carries a data (or parity) bit.
- frame_start  output  1  registered one-cycle pulse coincident with each word's MSB.
- busy  output  1  high whenever state != IDLE or hold_full.

Behaviour:
- Reset (async): state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0, hold_full=0, serial_out=IDLE_BIT, serial_valid=0, frame_start=0, in_ready=1, busy=0.
- Reset asserted mid-word aborts the word and drops the held word; nothing resumes after release.
- Accept: at an edge where in_valid && in_ready, in_data is written to hold and hold_full is set.
- in_data is don't-care when in_valid=0. in_valid may drop without acceptance.
- States: IDLE, SHIFT, GAP. Encodings are 2-bit localparams.
- IDLE:
  - If hold_full: load shift_reg from hold, clear hold_full, drive serial_out=MSB, serial_valid=1, frame_start=1, bit_cnt=1, go to SHIFT.
  - Else: serial_out=IDLE_BIT, serial_valid=0.
- SHIFT: each edge outputs the next bit, MSB to LSB, and increments bit_cnt. After the edge that outputs the last bit (bit_cnt==WIDTH):
  - If GAP>0: go to GAP with gap_cnt=0.
  - Else if hold_full: reload exactly as in IDLE, so the next MSB follows the previous LSB on the very next cycle.
  - Else: go to IDLE.
- GAP:
  - serial_out=IDLE_BIT, serial_valid=0 for exactly GAP cycles.
  - Then reload from hold if hold_full, else go to IDLE.
- Latency: word accepted at edge T0 gives MSB on serial_out from edge T0+1; the LSB is visible from edge T0+WIDTH.
- Simultaneous load and accept: on an edge where hold empties into shift_reg, in_ready was 0 (hold full), so no accept occurs that edge. in_ready rises the following cycle.
- Throughput: GAP=0 with hold kept full yields continuous serial_valid=1.
- frame_start is never high when serial_valid=0.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined: one even-parity bit (XOR of the word) is sent after the LSB, with serial_valid=1. Each frame is WIDTH+1 cycles; the bit_cnt terminal value is WIDTH+1.
- Undefined: frames are WIDTH bits and no parity logic is synthesised.

Decomposition:
- Shared package/header ser_pkg: state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_GAP=2'd2; the parity-enable derived frame length constant.
- One sub-module, ser_bit_counter: loadable up-counter with terminal-count flag, reused for bit_cnt and gap_cnt.
- FSM, hold register and shifter stay in the top.

Test Plan:
1. WIDTH=6, GAP=0, send 6'b010110 once -> serial_out = 0,1,0,1,1,0 on six consecutive cycles from edge T0+1; frame_start only on the first; then IDLE_BIT=1 with serial_valid=0. The downstream detector fires once.
2. WIDTH=8, GAP=0, in_valid held high with words 8'hA5, 8'h3C -> 16 contiguous serial_valid cycles carrying 10100101 00111100; frame_start at cycles 1 and 9. in_ready low while hold is full.
3. WIDTH=8, GAP=3, two words -> exactly 3 cycles of serial_out=1, serial_valid=0 between the LSB of word 1 and the MSB of word 2.
4. rst pulsed at the 4th bit of 8'hFF with a second word held -> serial_out=1, serial_valid=0, in_ready=1 immediately. No further bits after release until a new accept.
5. in_valid pulsed while in_ready=0 -> word not captured. Output stream is unchanged and the word is absent.
6. SER_PARITY_EN defined, WIDTH=8, send 8'h07 -> 9 valid bits 00000111 followed by 1.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the word serializer: FSM state encodings and the
// frame-length helper. Build option: SER_PARITY_EN appends an even-parity bit
// to every frame.
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

`ifdef SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter width covers the longest frame (32 data bits + parity) and the
  // largest gap.
  localparam int CNT_W = 6;

  // Number of serial cycles that carry frame bits for a word of the given width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/ser_word_serializer_if.sv
// Parallel-word input handshake and serial output bundle of the serializer.
interface ser_word_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;

  // Upstream side: supplies words and observes the serial stream.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  busy
  );

  // Serializer side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Loadable up-counter with a terminal-count flag; used for both the bit
// position within a frame and the inter-word gap length.
module ser_bit_counter #(
  parameter int CW   = 6,
  parameter int TERM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  output logic          tc
);

  logic [CW-1:0] cnt;

  // Load takes priority over increment; reset clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(TERM));

endmodule

// File: rtl/ser_word_serializer.sv
// Word serializer: accepts parallel words over valid/ready into a one-word
// holding register and shifts them out MSB-first, one bit per clk.
// Optional build macro SER_PARITY_EN: append an even-parity bit after the LSB.
module ser_word_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  ser_word_serializer_if.slave bus
);

  localparam int FW       = frame_len(WIDTH);
  localparam int GAP_TERM = (GAP > 0) ? GAP - 1 : 0;

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic             hold_clr;
  logic             accept;
  logic [FW-1:0]    frame_word;
  logic [FW-1:0]    shift_reg, shift_n;
  logic             so_r, so_n;
  logic             sv_r, sv_n;
  logic             fs_r, fs_n;
  logic             reload;
  logic             bit_load, bit_inc, bit_tc;
  logic             gap_load, gap_inc, gap_tc;

  // Hold is only written while empty, so an accept never coincides with the
  // edge that empties it into the shifter.
  assign accept = bus.in_valid && !hold_full;

`ifdef SER_PARITY_EN
  assign frame_word = {hold_reg, ^hold_reg};
`else
  assign frame_word = hold_reg;
`endif

  ser_bit_counter #(
    .CW   (CNT_W),
    .TERM (FW)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (CNT_W'(1)),
    .inc      (bit_inc),
    .tc       (bit_tc)
  );

  ser_bit_counter #(
    .CW   (CNT_W),
    .TERM (GAP_TERM)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (CNT_W'(0)),
    .inc      (gap_inc),
    .tc       (gap_tc)
  );

  // Holding register: filled on accept, emptied when the FSM reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= bus.in_data;
      hold_full <= 1'b1;
    end else if (hold_clr) begin
      hold_full <= 1'b0;
    end
  end

  // State, shifter and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      so_r      <= IDLE_BIT;
      sv_r      <= 1'b0;
      fs_r      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      so_r      <= so_n;
      sv_r      <= sv_n;
      fs_r      <= fs_n;
    end
  end

  // Next-state and next-output decode; a reload is shared by IDLE, the end of
  // a frame with no gap, and the end of a gap.
  always_comb begin
    state_n  = state;
    shift_n  = shift_reg;
    so_n     = IDLE_BIT;
    sv_n     = 1'b0;
    fs_n     = 1'b0;
    hold_clr = 1'b0;
    bit_load = 1'b0;
    bit_inc  = 1'b0;
    gap_load = 1'b0;
    gap_inc  = 1'b0;
    reload   = 1'b0;

    case (state)
      S_IDLE: begin
        if (hold_full) begin
          reload = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!bit_tc) begin
          shift_n = shift_reg << 1;
          so_n    = shift_reg[FW-2];
          sv_n    = 1'b1;
          bit_inc = 1'b1;
        end else if (GAP > 0) begin
          state_n  = S_GAP;
          gap_load = 1'b1;
        end else if (hold_full) begin
          reload = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (!gap_tc) begin
          gap_inc = 1'b1;
        end else if (hold_full) begin
          reload = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (reload) begin
      state_n  = S_SHIFT;
      shift_n  = frame_word;
      so_n     = frame_word[FW-1];
      sv_n     = 1'b1;
      fs_n     = 1'b1;
      hold_clr = 1'b1;
      bit_load = 1'b1;
    end
  end

  assign bus.in_ready     = ~hold_full;
  assign bus.serial_out   = so_r;
  assign bus.serial_valid = sv_r;
  assign bus.frame_start  = fs_r;
  assign bus.busy         = (state != S_IDLE) || hold_full;

endmodule

// File: tb/tb_ser_word_serializer.sv
// Directed bench for ser_word_serializer: three instances (WIDTH=6/GAP=0,
// WIDTH=8/GAP=0, WIDTH=8/GAP=3) share clk and rst. Expected streams are
// hand-written bit strings; parity characters are appended when
// SER_PARITY_EN is defined.
module tb_ser_word_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din [3];
  logic       vin [3];
  logic       so  [3];
  logic       sv  [3];
  logic       fs  [3];
  logic       rdy [3];
  logic       bsy [3];

  int n_cmp = 0;
  int n_bad = 0;

  ser_word_serializer_if #(.WIDTH(6)) if0 ();
  ser_word_serializer_if #(.WIDTH(8)) if1 ();
  ser_word_serializer_if #(.WIDTH(8)) if2 ();

  ser_word_serializer #(.WIDTH(6), .GAP(0), .IDLE_BIT(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ser_word_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  ser_word_serializer #(.WIDTH(8), .GAP(3), .IDLE_BIT(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_data = din[0][5:0];
  assign if1.in_data = din[1];
  assign if2.in_data = din[2];
  assign if0.in_valid = vin[0];
  assign if1.in_valid = vin[1];
  assign if2.in_valid = vin[2];

  assign so[0] = if0.serial_out;   assign so[1] = if1.serial_out;   assign so[2] = if2.serial_out;
  assign sv[0] = if0.serial_valid; assign sv[1] = if1.serial_valid; assign sv[2] = if2.serial_valid;
  assign fs[0] = if0.frame_start;  assign fs[1] = if1.frame_start;  assign fs[2] = if2.frame_start;
  assign rdy[0] = if0.in_ready;    assign rdy[1] = if1.in_ready;    assign rdy[2] = if2.in_ready;
  assign bsy[0] = if0.busy;        assign bsy[1] = if1.busy;        assign bsy[2] = if2.busy;

  typedef struct {
    int         sel;
    logic [7:0] word;
    string      so_e;
    string      sv_e;
    string      fs_e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bitc(input string s, input int i);
    return (s[i] == "1");
  endfunction

  // Sends w0 (and w1 with valid held high when two=1), optionally pulses a
  // third word while hold is full, and compares {serial_valid, frame_start,
  // serial_out} every cycle from edge T0+1 against the expected strings.
  task automatic run_stream(input string tag, input int sel,
                            input logic [7:0] w0, input logic [7:0] w1, input bit two,
                            input int pulse_at, input logic [7:0] pw,
                            input string so_e, input string sv_e, input string fs_e);
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(rdy[sel]), 32'd1);
    chk({tag, " busy_idle"}, 32'(bsy[sel]), 32'd0);
    din[sel] = w0;
    vin[sel] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " ready_after_accept"}, 32'(rdy[sel]), 32'd0);
    if (two) din[sel] = w1;
    else vin[sel] = 1'b0;
    for (int i = 0; i < so_e.len(); i++) begin
      @(posedge clk);
      if ((two && i == 1) || i == pulse_at + 1) begin
        #1;
        vin[sel] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("%s cyc%0d", tag, i), {29'd0, sv[sel], fs[sel], so[sel]},
          {29'd0, bitc(sv_e, i), bitc(fs_e, i), bitc(so_e, i)});
      if (two && i == 1) chk({tag, " ready_hold_full"}, 32'(rdy[sel]), 32'd0);
      if (i == pulse_at) begin
        chk({tag, " ready_at_pulse"}, 32'(rdy[sel]), 32'd0);
        din[sel] = pw;
        vin[sel] = 1'b1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    string p0, p1, pv, pz;

`ifdef SER_PARITY_EN
    p0 = "0"; p1 = "1"; pv = "1"; pz = "0";
`else
    p0 = "";  p1 = "";  pv = "";  pz = "";
`endif

    vecs[0] = '{0, 8'b0001_0110, {"010110", p1, "1"},   {"111111", pv, "0"},   {"100000", pz, "0"}};
    vecs[1] = '{0, 8'b0010_0001, {"100001", p0, "1"},   {"111111", pv, "0"},   {"100000", pz, "0"}};
    vecs[2] = '{1, 8'h07,        {"00000111", p1, "1"}, {"11111111", pv, "0"}, {"10000000", pz, "0"}};
    vecs[3] = '{1, 8'hA5,        {"10100101", p0, "1"}, {"11111111", pv, "0"}, {"10000000", pz, "0"}};
    vecs[4] = '{2, 8'h3C,        {"00111100", p0, "1"}, {"11111111", pv, "0"}, {"10000000", pz, "0"}};
    vecs[5] = '{1, 8'h80,        {"10000000", p1, "1"}, {"11111111", pv, "0"}, {"10000000", pz, "0"}};

    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00;
      vin[k] = 1'b0;
    end
    rst = 1'b1;
    #12;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state dut%0d", k), {27'd0, so[k], sv[k], fs[k], rdy[k], bsy[k]}, 32'b10010);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // Back-to-back words, GAP=0: 16 contiguous valid bits.
    run_stream("b2b", 1, 8'hA5, 8'h3C, 1'b1, -10, 8'h00,
               {"10100101", p0, "00111100", p0, "1"},
               {"11111111", pv, "11111111", pv, "0"},
               {"10000000", pz, "10000000", pz, "0"});
    idle_cycles(4);

    // GAP=3: exactly three idle cycles between the words.
    run_stream("gap3", 2, 8'hA5, 8'h3C, 1'b1, -10, 8'h00,
               {"10100101", p0, "111", "00111100", p0, "1"},
               {"11111111", pv, "000", "11111111", pv, "0"},
               {"10000000", pz, "000", "10000000", pz, "0"});
    idle_cycles(8);

    // Valid pulsed while hold is full: the third word must never appear.
    run_stream("no_capture", 0, 8'b0011_0011, 8'b0000_1010, 1'b1, 3, 8'h3F,
               {"110011", p0, "001010", p0, "1"},
               {"111111", pv, "111111", pv, "0"},
               {"100000", pz, "100000", pz, "0"});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("no_capture tail%0d", i), {30'd0, sv[0], so[0]}, 32'b01);
    end

    // Reset during the 4th bit of 8'hFF with a second word held.
    @(negedge clk);
    din[1] = 8'hFF;
    vin[1] = 1'b1;
    @(posedge clk);
    #1;
    din[1] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      if (i == 1) begin
        #1;
        vin[1] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("rst_mid bit%0d", i), {30'd0, sv[1], so[1]}, 32'b11);
    end
    chk("rst_mid hold_full", {30'd0, rdy[1], bsy[1]}, 32'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid immediate", {27'd0, so[1], sv[1], fs[1], rdy[1], bsy[1]}, 32'b10010);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid after%0d", i), {29'd0, sv[1], fs[1], so[1]}, 32'b001);
    end
    chk("rst_mid idle_busy", 32'(bsy[1]), 32'd0);

    // Single-word vectors.
    for (int v = 0; v < 6; v++) begin
      run_stream($sformatf("vec%0d", v), vecs[v].sel, vecs[v].word, 8'h00, 1'b0, -10, 8'h00,
                 vecs[v].so_e, vecs[v].sv_e, vecs[v].fs_e);
      idle_cycles(6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
